// File: rtl/fma_lza_pipe.sv
// Two-stage leading-zero anticipation checker for an FMA adder: stage 1 forms the LZA
// indicator vector F and the true sum S, stage 2 counts leading zeros of both and flags mismatches.
module fma_lza_pipe #(
    parameter int NF  = 52,
    parameter int CCW = 16,
    localparam int WIDTH = 3*NF+6,
    localparam int CW    = $clog2(WIDTH+2)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] A,
    input  logic [2*NF+1:0]  Pm,
    input  logic             Cin,
    input  logic             Sub,
    input  logic             Flush,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [CW-1:0]    SCnt,
    output logic [CW-1:0]    ECnt,
    output logic             Err,
    output logic [CCW-1:0]   CorrCnt,
    input  logic             CorrClr
);

    // Leading zeros counted from the MSB; an all-zero vector yields its full width.
    function automatic logic [CW-1:0] lzc(input logic [WIDTH:0] v);
        logic [CW-1:0] n;
        n = CW'(WIDTH + 1);
        for (int i = 0; i <= WIDTH; i++) begin
            if (v[i]) n = CW'(WIDTH - i);
        end
        return n;
    endfunction

    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] pp1;
    logic [WIDTH-1:0] gm1;
    logic [WIDTH-1:0] km1;
    logic [WIDTH-1:0] s_sum;
    logic [WIDTH:0]   f_ind;

    logic             s2_adv;
    logic             s1_move;
    logic             accept;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH:0]   s1_f_q, s1_f_d;
    logic [WIDTH-1:0] s1_s_q, s1_s_d;
    logic             s2_valid_q, s2_valid_d;
    logic [CW-1:0]    scnt_q, scnt_d;
    logic [CW-1:0]    ecnt_q, ecnt_d;
    logic             err_q, err_d;
    logic [CCW-1:0]   corr_cnt_q, corr_cnt_d;

    assign b   = {{(NF+2){1'b0}}, Pm, 2'b00};
    assign g   = A & b;
    assign k   = ~A & ~b;
    assign pp1 = {Sub, A[WIDTH-1:1] ^ b[WIDTH-1:1]};
    assign gm1 = {g[WIDTH-2:0], Cin};
    assign km1 = {k[WIDTH-2:0], ~Cin};

    assign f_ind[WIDTH]     = ~Sub & (A[WIDTH-1] ^ b[WIDTH-1]);
    assign f_ind[WIDTH-1:0] = (pp1 & ((g & ~km1) | (k & ~gm1)))
                            | (~pp1 & ((k & ~km1) | (g & ~gm1)));
    assign s_sum = A + b + {{(WIDTH-1){1'b0}}, Cin};

    assign s2_adv  = ~s2_valid_q | OutReady;
    assign s1_move = s1_valid_q & s2_adv;
    // Flush empties both stages at the next edge, so the port may advertise space during it.
    assign InReady = ~s1_valid_q | s2_adv | Flush;
    assign accept  = InValid & InReady & ~Flush;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_f_d     = s1_f_q;
        s1_s_d     = s1_s_q;
        s2_valid_d = s2_valid_q;
        scnt_d     = scnt_q;
        ecnt_d     = ecnt_q;
        err_d      = err_q;
        corr_cnt_d = corr_cnt_q;

        if (accept) begin
            s1_f_d = f_ind;
            s1_s_d = s_sum;
        end

        if (s1_move) begin
            scnt_d = lzc(s1_f_q);
            ecnt_d = lzc({s1_s_q, 1'b0});
            err_d  = (scnt_d != ecnt_d);
        end

        if (Flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (s2_adv) s2_valid_d = s1_valid_q;
            if (accept) begin
                s1_valid_d = 1'b1;
            end else if (s1_move) begin
                s1_valid_d = 1'b0;
            end
        end

        if (CorrClr) begin
            corr_cnt_d = '0;
        end else if (s2_valid_q && OutReady && err_q && (corr_cnt_q != {CCW{1'b1}})) begin
            corr_cnt_d = corr_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_f_q     <= '0;
            s1_s_q     <= '0;
            s2_valid_q <= 1'b0;
            scnt_q     <= '0;
            ecnt_q     <= '0;
            err_q      <= 1'b0;
            corr_cnt_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_f_q     <= s1_f_d;
            s1_s_q     <= s1_s_d;
            s2_valid_q <= s2_valid_d;
            scnt_q     <= scnt_d;
            ecnt_q     <= ecnt_d;
            err_q      <= err_d;
            corr_cnt_q <= corr_cnt_d;
        end
    end

    assign OutValid = s2_valid_q;
    assign SCnt     = scnt_q;
    assign ECnt     = ecnt_q;
    assign Err      = err_q;
    assign CorrCnt  = corr_cnt_q;

endmodule

// File: tb/tb_fma_lza_pipe.sv
// Bench for fma_lza_pipe at NF=2: directed steps plus random operands scored against
// an arithmetic reference model; a second instance with CCW=2 exercises counter saturation.
module tb_fma_lza_pipe;
    localparam int NF    = 2;
    localparam int WIDTH = 12;
    localparam int CW    = 4;

    logic clk = 1'b0;
    logic reset_n, InValid, Cin, Sub, Flush, OutReady, CorrClr;
    logic [WIDTH-1:0] A;
    logic [2*NF+1:0]  Pm;
    logic InReady, OutValid, Err;
    logic [CW-1:0] SCnt, ECnt;
    logic [15:0]   CorrCnt;
    logic InReady2, OutValid2, Err2;
    logic [CW-1:0] SCnt2, ECnt2;
    logic [1:0]    CorrCnt2;

    fma_lza_pipe #(.NF(NF), .CCW(16)) dut (
        .clk(clk), .reset_n(reset_n), .InValid(InValid), .InReady(InReady),
        .A(A), .Pm(Pm), .Cin(Cin), .Sub(Sub), .Flush(Flush),
        .OutValid(OutValid), .OutReady(OutReady), .SCnt(SCnt), .ECnt(ECnt),
        .Err(Err), .CorrCnt(CorrCnt), .CorrClr(CorrClr)
    );

    fma_lza_pipe #(.NF(NF), .CCW(2)) dut_sat (
        .clk(clk), .reset_n(reset_n), .InValid(InValid), .InReady(InReady2),
        .A(A), .Pm(Pm), .Cin(Cin), .Sub(Sub), .Flush(Flush),
        .OutValid(OutValid2), .OutReady(OutReady), .SCnt(SCnt2), .ECnt(ECnt2),
        .Err(Err2), .CorrCnt(CorrCnt2), .CorrClr(CorrClr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] s;
        logic [3:0] e;
        logic       err;
    } res_t;

    res_t expq[$];
    int checks = 0;
    int errors = 0;
    int npop   = 0;
    int corr16 = 0;
    int corr2  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int bitlen(input int v);
        int n = 0;
        while (v > 0) begin
            v = v >> 1;
            n++;
        end
        return n;
    endfunction

    // Reference: indicator and sum built bit by bit with integers, counts from bit length.
    function automatic res_t model(input int a, input int pm, input int cin, input int sub);
        res_t r;
        int b, s, f, pp, gm, km, gi, ki, fb, j;
        b = pm * 4;
        s = (a + b + cin) % 4096;
        f = 0;
        for (int i = 0; i < 12; i++) begin
            j  = (i > 0) ? i - 1 : 0;
            gi = (a >> i) & (b >> i) & 1;
            ki = (~(a >> i)) & (~(b >> i)) & 1;
            pp = (i == 11) ? sub : (((a >> (i + 1)) ^ (b >> (i + 1))) & 1);
            gm = (i == 0) ? cin : ((a >> j) & (b >> j) & 1);
            km = (i == 0) ? 1 - cin : ((~(a >> j)) & (~(b >> j)) & 1);
            if (pp == 1) fb = (gi & (1 - km)) | (ki & (1 - gm));
            else         fb = (ki & (1 - km)) | (gi & (1 - gm));
            f += fb << i;
        end
        if (sub == 0 && (((a ^ b) >> 11) & 1) == 1) f += 1 << 12;
        r.s   = 4'(13 - bitlen(f));
        r.e   = 4'(13 - bitlen(s * 2));
        r.err = (r.s != r.e);
        return r;
    endfunction

    task automatic drive(input logic v, input int a, input int pm, input int cin, input int sub);
        InValid = v;
        A       = 12'(a);
        Pm      = 6'(pm);
        Cin     = 1'(cin);
        Sub     = 1'(sub);
    endtask

    task automatic drive_rand();
        drive(1'b1, int'($urandom_range(0, 4095)), int'($urandom_range(0, 63)),
              int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
    endtask

    // One clock: score handshakes at the negedge, then step past the rising edge.
    task automatic tick();
        res_t r;
        logic pop_err;
        @(negedge clk);
        pop_err = 1'b0;
        if (reset_n && OutValid && OutReady) begin
            if (expq.size() == 0) begin
                chk("spurious_out", 32'(expq.size()), 1);
            end else begin
                r = expq.pop_front();
                npop++;
                chk("scnt", 32'(SCnt), 32'(r.s));
                chk("ecnt", 32'(ECnt), 32'(r.e));
                chk("err", 32'(Err), 32'(r.err));
                pop_err = r.err;
                $display("out #%0d SCnt=%0d ECnt=%0d Err=%0d", npop, SCnt, ECnt, Err);
            end
        end
        if (reset_n) begin
            if (CorrClr) begin
                corr16 = 0;
                corr2  = 0;
            end else if (pop_err) begin
                if (corr16 < 65535) corr16++;
                if (corr2 < 3) corr2++;
            end
        end
        if (reset_n && InValid && InReady && !Flush)
            expq.push_back(model(int'(A), int'(Pm), int'(Cin), int'(Sub)));
        if (reset_n && Flush) expq.delete();
        @(posedge clk);
        #1;
        chk("corrcnt16", 32'(CorrCnt), 32'(corr16));
        chk("corrcnt2", 32'(CorrCnt2), 32'(corr2));
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 8 && expq.size() > 0; i++) tick();
        chk(tag, 32'(expq.size()), 0);
    endtask

    int ea, ep, ec, es, base;
    res_t tr;
    logic found;

    initial begin
        reset_n = 1'b0; CorrClr = 1'b0; Flush = 1'b0; OutReady = 1'b1;
        drive(1'b0, 0, 0, 0, 0);
        #2;
        chk("rst_ov", 32'(OutValid), 0);
        chk("rst_scnt", 32'(SCnt), 0);
        chk("rst_ecnt", 32'(ECnt), 0);
        chk("rst_err", 32'(Err), 0);
        chk("rst_corr", 32'(CorrCnt), 0);
        chk("rst_inready", 32'(InReady), 1);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Zero operand: two-cycle latency, full-width counts.
        drive(1'b1, 0, 0, 0, 0);
        tick();
        chk("zero_lat1_ov", 32'(OutValid), 0);
        drive(1'b0, 0, 0, 0, 0);
        tick();
        chk("zero_lat2_ov", 32'(OutValid), 1);
        chk("zero_scnt", 32'(SCnt), 13);
        chk("zero_ecnt", 32'(ECnt), 13);
        chk("zero_err", 32'(Err), 0);
        tick();

        // Top addend bit set.
        drive(1'b1, 12'h800, 0, 0, 0);
        tick();
        drive(1'b0, 0, 0, 0, 0);
        tick();
        chk("top_scnt", 32'(SCnt), 0);
        chk("top_ecnt", 32'(ECnt), 0);
        chk("top_err", 32'(Err), 0);
        tick();

        // Back-to-back stream of 20 random operands.
        base = npop;
        for (int i = 0; i < 20; i++) begin
            drive_rand();
            chk("stream_inready", 32'(InReady), 1);
            tick();
        end
        drive(1'b0, 0, 0, 0, 0);
        tick();
        tick();
        chk("stream_count", 32'(npop - base), 20);

        // Backpressure: two entries held, then the input stalls.
        OutReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_rand();
            tick();
            if (i >= 2) begin
                chk("bp_hold_scnt", 32'(SCnt), 32'(expq[0].s));
                chk("bp_hold_ecnt", 32'(ECnt), 32'(expq[0].e));
                chk("bp_hold_err", 32'(Err), 32'(expq[0].err));
            end
        end
        chk("bp_entries", 32'(expq.size()), 2);
        chk("bp_inready", 32'(InReady), 0);
        chk("bp_ov", 32'(OutValid), 1);
        OutReady = 1'b1;
        drive(1'b0, 0, 0, 0, 0);
        drain("bp_drain");

        // Random handshake pattern.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) drive_rand();
            else drive(1'b0, 0, 0, 0, 0);
            OutReady = 1'($urandom_range(0, 1));
            tick();
        end
        OutReady = 1'b1;
        drive(1'b0, 0, 0, 0, 0);
        drain("rand_drain");

        // Flush with two entries in flight; the coinciding offer is dropped.
        OutReady = 1'b0;
        drive_rand(); tick();
        drive_rand(); tick();
        drive_rand();
        Flush = 1'b1;
        #1;
        chk("flush_inready", 32'(InReady), 1);
        tick();
        Flush = 1'b0;
        chk("flush_ov", 32'(OutValid), 0);
        OutReady = 1'b1;
        drive_rand(); tick();
        drive(1'b0, 0, 0, 0, 0);
        chk("flush_next_lat1", 32'(OutValid), 0);
        tick();
        chk("flush_next_lat2", 32'(OutValid), 1);
        tick();
        chk("flush_drain", 32'(expq.size()), 0);

        // Find an operand whose anticipation is off.
        found = 1'b0;
        for (int i = 0; i < 4000 && !found; i++) begin
            ea = int'($urandom_range(0, 4095)); ep = int'($urandom_range(0, 63));
            ec = int'($urandom_range(0, 1));    es = int'($urandom_range(0, 1));
            tr = model(ea, ep, ec, es);
            if (tr.err) found = 1'b1;
        end
        chk("err_operand_found", 32'(found), 1);

        // Saturation of the 2-bit counter, then clear beating an increment.
        CorrClr = 1'b1; tick(); CorrClr = 1'b0;
        chk("corr_cleared", 32'(CorrCnt2), 0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, ea, ep, ec, es);
            tick();
        end
        drive(1'b0, 0, 0, 0, 0);
        tick(); tick();
        chk("corr2_sat", 32'(CorrCnt2), 3);
        chk("corr16_five", 32'(CorrCnt), 5);
        drive(1'b1, ea, ep, ec, es); tick();
        drive(1'b0, 0, 0, 0, 0); tick();
        chk("clr_err_pending", 32'(OutValid & Err), 1);
        CorrClr = 1'b1; tick(); CorrClr = 1'b0;
        chk("clr_prio16", 32'(CorrCnt), 0);
        chk("clr_prio2", 32'(CorrCnt2), 0);

        // Reset with two entries in flight and a nonzero counter.
        drive(1'b1, ea, ep, ec, es); tick();
        drive(1'b0, 0, 0, 0, 0); tick(); tick();
        chk("pre_rst_corr", 32'(CorrCnt), 1);
        OutReady = 1'b0;
        drive_rand(); tick();
        drive_rand(); tick();
        reset_n = 1'b0;
        #1;
        chk("rst_mid_ov", 32'(OutValid), 0);
        chk("rst_mid_corr", 32'(CorrCnt), 0);
        chk("rst_mid_inready", 32'(InReady), 1);
        expq.delete();
        corr16 = 0;
        corr2  = 0;
        OutReady = 1'b1;
        tick(); tick();
        chk("rst_hold_ov", 32'(OutValid), 0);
        reset_n = 1'b1;
        drive_rand(); tick();
        drive(1'b0, 0, 0, 0, 0);
        chk("rst_next_lat1", 32'(OutValid), 0);
        tick();
        chk("rst_next_lat2", 32'(OutValid), 1);
        tick();
        chk("rst_drain", 32'(expq.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
